// File: rtl/data_memory_subword.sv
// data_memory_subword: byte-addressable RV32 data RAM with LB/LH/LW/LBU/LHU/SB/SH/SW,
// registered one-cycle response and an optional zero-clear sweep after reset.
module data_memory_subword #(
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 2 ** WA_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q, state_d;
    logic [WA_W-1:0] clear_ptr_q, clear_ptr_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_err_q;
    logic [31:0]     rsp_rdata_q;
    logic [31:0]     mem [DEPTH];

    logic [WA_W-1:0] word;
    logic [1:0]      off, size;
    logic            bad_f3, misal, oor, err, accept, wr_en;
    logic [3:0]      be;
    logic [31:0]     wsh, rsh, ld;

    assign word   = req_addr[ADDR_W-1:2];
    assign off    = req_addr[1:0];
    assign size   = req_funct3[1:0];
    // 011/110/111 are never legal; unsigned variants make no sense for stores
    assign bad_f3 = (size == 2'b11) || (req_funct3[2] && req_funct3[1]) || (req_we && req_funct3[2]);
    assign misal  = (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
    assign oor    = |req_addr[31:ADDR_W];
    assign err    = bad_f3 || misal || oor;
    assign accept = req_valid && ready_q;
    assign wr_en  = accept && req_we && !err;

    assign be  = size == 2'b00 ? 4'b0001 << off : size == 2'b01 ? 4'b0011 << off : 4'b1111;
    assign wsh = req_wdata << {off, 3'b000};
    assign rsh = mem[word] >> {off, 3'b000};
    assign ld  = size == 2'b00 ? {{24{~req_funct3[2] & rsh[7]}}, rsh[7:0]}
               : size == 2'b01 ? {{16{~req_funct3[2] & rsh[15]}}, rsh[15:0]}
               : rsh;

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        if (state_q == CLEAR) begin
            clear_ptr_d = clear_ptr_q + WA_W'(1);
            if (&clear_ptr_q) state_d = RUN;
        end
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clear_ptr_q <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            ready_q     <= ready_d;
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || req_we) ? '0 : ld;
            end
        end
    end

    // Write lands at the accept edge, so a load on the next cycle sees it without bypass
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            mem[clear_ptr_q] <= '0;
        else if (wr_en)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[word][8*k +: 8] <= wsh[8*k +: 8];
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_memory_subword.sv
// tb_data_memory_subword: directed sub-word load/store vectors checked through a response scoreboard.
module tb_data_memory_subword;
    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int          checks = 0, errors = 0;
    int          cyc = 0, prev_rsp = -10, last_rsp = -10;
    logic [32:0] exp_q[$];
    string       name_q[$];
    logic [32:0] exp_e;
    string       exp_n;

    data_memory_subword #(.ADDR_W(10), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [32:0] act, logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            prev_rsp = last_rsp;
            last_rsp = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got err=%b data=%h expected no response", rsp_err, rsp_rdata);
            end else begin
                exp_e = exp_q.pop_front();
                exp_n = name_q.pop_front();
                chk(exp_n, {rsp_err, rsp_rdata}, exp_e);
            end
        end
    end

    task automatic issue(string nm, logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                         logic e_err, logic [31:0] e_d);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        exp_q.push_back({e_err, e_d});
        name_q.push_back(nm);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_ready(string nm, int exp_cycles);
        int n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n, exp_cycles);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_err", rsp_err, 0);
        rst_n = 1'b1;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
        wait_ready("clear_ready_cycles", 256);
        req_valid = 1'b0;

        issue("lw_3fc_cleared", 0, 3'b010, 32'h3FC, 0, 0, 32'h0);
        issue("lw_10_cleared", 0, 3'b010, 32'h10, 0, 0, 32'h0);
        issue("sw_10", 1, 3'b010, 32'h10, 32'h1122_3344, 0, 32'h0);
        issue("sb_11", 1, 3'b000, 32'h11, 32'h1234_56AB, 0, 32'h0);
        issue("lw_10_merged", 0, 3'b010, 32'h10, 0, 0, 32'h1122_AB44);
        issue("lb_11", 0, 3'b000, 32'h11, 0, 0, 32'hFFFF_FFAB);
        issue("lbu_11", 0, 3'b100, 32'h11, 0, 0, 32'h0000_00AB);
        issue("lb_13_pos", 0, 3'b000, 32'h13, 0, 0, 32'h0000_0011);
        issue("lh_10", 0, 3'b001, 32'h10, 0, 0, 32'hFFFF_AB44);
        issue("lhu_12", 0, 3'b101, 32'h12, 0, 0, 32'h0000_1122);

        issue("sh_22", 1, 3'b001, 32'h22, 32'h5A5A_8001, 0, 32'h0);
        issue("lh_22", 0, 3'b001, 32'h22, 0, 0, 32'hFFFF_8001);
        issue("lhu_22", 0, 3'b101, 32'h22, 0, 0, 32'h0000_8001);
        issue("lh_21_misal", 0, 3'b001, 32'h21, 0, 1, 32'h0);
        issue("sh_21_misal", 1, 3'b001, 32'h21, 32'h0000_FFFF, 1, 32'h0);
        issue("lw_20_unchanged", 0, 3'b010, 32'h20, 0, 0, 32'h8001_0000);
        issue("lw_12_misal", 0, 3'b010, 32'h12, 0, 1, 32'h0);

        issue("sw_400_oor", 1, 3'b010, 32'h400, 32'hCAFE_F00D, 1, 32'h0);
        issue("lw_0_not_aliased", 0, 3'b010, 32'h0, 0, 0, 32'h0);
        issue("lw_400_oor", 0, 3'b010, 32'h400, 0, 1, 32'h0);
        issue("load_f3_011", 0, 3'b011, 32'h0, 0, 1, 32'h0);
        issue("load_f3_111", 0, 3'b111, 32'h0, 0, 1, 32'h0);
        issue("store_f3_100", 1, 3'b100, 32'h30, 32'hFFFF_FFFF, 1, 32'h0);
        issue("lw_30_unchanged", 0, 3'b010, 32'h30, 0, 0, 32'h0);
        issue("sb_3ff", 1, 3'b000, 32'h3FF, 32'h0000_007F, 0, 32'h0);
        issue("lw_3fc_top", 0, 3'b010, 32'h3FC, 0, 0, 32'h7F00_0000);
        issue("lb_3ff", 0, 3'b000, 32'h3FF, 0, 0, 32'h0000_007F);

        issue("sw_8_b2b", 1, 3'b010, 32'h8, 32'hDEAD_BEEF, 0, 32'h0);
        issue("lw_8_b2b", 0, 3'b010, 32'h8, 0, 0, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        chk("b2b_consecutive", last_rsp - prev_rsp, 1);

        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("pre_reset_rsp_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_rsp_valid", rsp_valid, 0);
        chk("async_reset_ready", req_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        wait_ready("midclear_ready_cycles", 256);
        issue("lw_8_after_sweep", 0, 3'b010, 32'h8, 0, 0, 32'h0);
        issue("lw_20_after_sweep", 0, 3'b010, 32'h20, 0, 0, 32'h0);
        issue("lw_3fc_after_sweep", 0, 3'b010, 32'h3FC, 0, 0, 32'h0);

        begin
            int n = 0;
            while (exp_q.size() > 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("responses_outstanding", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
